shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 126 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential shift-and-add multiplier: a CHECK/ADD/SHIFT loop that exits early once the multiplier is zero.
// Optional MULT_SIGNED_EN macro: two's complement operands with a final FIX (negate) state.
module shift_add_multiplier #(
  parameter int WIDTH     = 16,
  parameter int DONE_HOLD = 21
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] PP,
  output logic               DONE,
  output logic               BUSY
);

  localparam int HOLD_W = $clog2(DONE_HOLD + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
`ifdef MULT_SIGNED_EN
    ST_FIX   = 3'd4,
`endif
    ST_END   = 3'd5
  } state_t;

  state_t              state_reg, state_next;
  logic [2*WIDTH-1:0]  md_reg;
  logic [WIDTH-1:0]    mr_reg;
  logic [2*WIDTH-1:0]  pp_reg;
  logic [HOLD_W-1:0]   hold_reg;
  logic                hold_last;
  logic [WIDTH-1:0]    a_mag;
  logic [WIDTH-1:0]    b_mag;

`ifdef MULT_SIGNED_EN
  logic sign_reg;

  // The most-negative value maps onto its own bit pattern, which reads correctly as an unsigned magnitude.
  assign a_mag = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
  assign b_mag = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;
`else
  assign a_mag = A;
  assign b_mag = B;
`endif

  assign hold_last = (hold_reg == HOLD_W'(DONE_HOLD - 1));

  // State register and datapath.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      md_reg    <= '0;
      mr_reg    <= '0;
      pp_reg    <= '0;
      hold_reg  <= '0;
`ifdef MULT_SIGNED_EN
      sign_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (START) begin
            md_reg <= {{WIDTH{1'b0}}, a_mag};
            mr_reg <= b_mag;
            pp_reg <= '0;
`ifdef MULT_SIGNED_EN
            sign_reg <= A[WIDTH-1] ^ B[WIDTH-1];
`endif
          end
        end
        ST_ADD: pp_reg <= pp_reg + md_reg;
        ST_SHIFT: begin
          md_reg <= md_reg << 1;
          mr_reg <= mr_reg >> 1;
        end
`ifdef MULT_SIGNED_EN
        ST_FIX: pp_reg <= sign_reg ? (~pp_reg + (2*WIDTH)'(1)) : pp_reg;
`endif
        ST_END: hold_reg <= hold_last ? '0 : hold_reg + HOLD_W'(1);
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (START) state_next = ST_CHECK;
      ST_CHECK: begin
        if (mr_reg == '0) begin
`ifdef MULT_SIGNED_EN
          state_next = ST_FIX;
`else
          state_next = ST_END;
`endif
        end else if (mr_reg[0]) begin
          state_next = ST_ADD;
        end else begin
          state_next = ST_SHIFT;
        end
      end
      ST_ADD:   state_next = ST_SHIFT;
      ST_SHIFT: state_next = ST_CHECK;
`ifdef MULT_SIGNED_EN
      ST_FIX:   state_next = ST_END;
`endif
      ST_END:   if (hold_last) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    DONE = (state_reg == ST_END);
    BUSY = (state_reg != ST_IDLE);
  end

  assign PP = pp_reg;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed-vector bench for shift_add_multiplier; build with +define+MULT_SIGNED_EN to cover the signed variant.
module tb_shift_add_multiplier;

  localparam int WIDTH = 16;
  localparam int HOLD  = 21;
`ifdef MULT_SIGNED_EN
  localparam int FIX_LAT = 1;
`else
  localparam int FIX_LAT = 0;
`endif

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               START = 1'b0;
  logic [WIDTH-1:0]   A = '0;
  logic [WIDTH-1:0]   B = '0;
  logic [2*WIDTH-1:0] PP;
  logic               DONE;
  logic               BUSY;

  int vectors = 0;
  int miscompares = 0;

  shift_add_multiplier #(.WIDTH(WIDTH), .DONE_HOLD(HOLD)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B),
    .PP(PP), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Pulse START (sampled at edge 0) and return the edge after which DONE first reads high, or -1.
  // A nonzero repulse_edge re-asserts START with A=1,B=1 so it is sampled at that edge.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int repulse_edge, output int lat);
    A = a; B = b; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge CLK); #1;
      if (DONE) begin lat = e; break; end
      if (repulse_edge != 0 && e == repulse_edge - 1) begin A = 1; B = 1; START = 1'b1; end
      if (repulse_edge != 0 && e == repulse_edge) START = 1'b0;
    end
  endtask

  // Count the consecutive samples with DONE high, starting from a sample where DONE is already high.
  task automatic count_done(output int hi);
    hi = 1;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (!DONE) break;
      hi++;
    end
  endtask

  task automatic wait_idle(output bit idle);
    idle = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!BUSY) begin idle = 1'b1; break; end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    int lat;
    bit idle;
    vectors++;
    if (PP !== 32'h0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: PP=%h DONE=%b BUSY=%b, required PP=0 DONE=0 BUSY=0", PP, DONE, BUSY);
    end
    A = 16'd7; B = 16'd5; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (4) begin @(posedge CLK); #1; end
    RST = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end
    RST = 1'b0;
    vectors++;
    if (PP !== 32'h0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_op_reset: PP=%h DONE=%b BUSY=%b, required PP=0 DONE=0 BUSY=0", PP, DONE, BUSY);
    end
    run_op(16'd2, 16'd3, 0, lat);
    vectors++;
    if (lat !== 7 + FIX_LAT || PP !== 32'd6) begin
      miscompares++;
      $display("FAIL after_reset_2x3: lat=%0d PP=%h, required lat=%0d PP=00000006", lat, PP, 7 + FIX_LAT);
    end
    wait_idle(idle);
    vectors++;
    if (!idle) begin miscompares++; $display("FAIL idle_timeout_reset: BUSY=%b, required 0", BUSY); end
    $display("test_reset: lat=%0d PP=%h", lat, PP);
  endtask

  task automatic test_zero_operands;
    int lat, hi;
    bit idle;
    run_op(16'h0003, 16'h0000, 0, lat);
    vectors++;
    if (lat !== 1 + FIX_LAT || PP !== 32'h0) begin
      miscompares++;
      $display("FAIL b_zero: lat=%0d PP=%h, required lat=%0d PP=00000000", lat, PP, 1 + FIX_LAT);
    end
    count_done(hi);
    vectors++;
    if (hi !== HOLD || BUSY !== 1'b0) begin
      miscompares++;
      $display("FAIL done_hold: DONE cycles=%0d BUSY after=%b, required %0d and 0", hi, BUSY, HOLD);
    end
    $display("test_zero_operands B=0: lat=%0d hold=%0d", lat, hi);
    run_op(16'h0000, 16'h1234, 0, lat);
    vectors++;
    if (lat !== 32 + FIX_LAT || PP !== 32'h0) begin
      miscompares++;
      $display("FAIL a_zero: lat=%0d PP=%h, required lat=%0d PP=00000000", lat, PP, 32 + FIX_LAT);
    end
    wait_idle(idle);
    vectors++;
    if (!idle) begin miscompares++; $display("FAIL idle_timeout_zero: BUSY=%b, required 0", BUSY); end
    $display("test_zero_operands A=0: lat=%0d PP=%h", lat, PP);
  endtask

  task automatic test_busy_ignore;
    int lat;
    bit idle;
    run_op(16'h0007, 16'h0005, 4, lat);
    vectors++;
    if (lat !== 9 + FIX_LAT || PP !== 32'h23) begin
      miscompares++;
      $display("FAIL busy_ignore_7x5: lat=%0d PP=%h, required lat=%0d PP=00000023", lat, PP, 9 + FIX_LAT);
    end
    repeat (5) begin @(posedge CLK); #1; end
    vectors++;
    if (PP !== 32'h23 || DONE !== 1'b1) begin
      miscompares++;
      $display("FAIL pp_frozen_in_end: PP=%h DONE=%b, required PP=00000023 DONE=1", PP, DONE);
    end
    wait_idle(idle);
    vectors++;
    if (!idle || PP !== 32'h23) begin
      miscompares++;
      $display("FAIL idle_keeps_result: idle=%b PP=%h, required 1 and 00000023", idle, PP);
    end
    $display("test_busy_ignore: lat=%0d PP=%h", lat, PP);
  endtask

  task automatic test_max_operands;
    int lat;
    bit idle;
    logic [31:0] exp_pp;
    int exp_lat;
`ifdef MULT_SIGNED_EN
    exp_pp = 32'h0000_0001; exp_lat = 5;
`else
    exp_pp = 32'hFFFE_0001; exp_lat = 49;
`endif
    run_op(16'hFFFF, 16'hFFFF, 0, lat);
    vectors++;
    if (lat !== exp_lat || PP !== exp_pp) begin
      miscompares++;
      $display("FAIL max_ffff: lat=%0d PP=%h, required lat=%0d PP=%h", lat, PP, exp_lat, exp_pp);
    end
    wait_idle(idle);
    vectors++;
    if (!idle) begin miscompares++; $display("FAIL idle_timeout_max: BUSY=%b, required 0", BUSY); end
    $display("test_max_operands: lat=%0d PP=%h", lat, PP);
  endtask

  task automatic test_back_to_back;
    int lat, hi, lo;
    bit idle;
    A = 16'd4; B = 16'd4; START = 1'b1;
    lat = -1;
    for (int e = 0; e <= 200; e++) begin
      @(posedge CLK); #1;
      if (DONE) begin lat = e; break; end
    end
    vectors++;
    if (lat !== 8 + FIX_LAT || PP !== 32'h10) begin
      miscompares++;
      $display("FAIL b2b_first: lat=%0d PP=%h, required lat=%0d PP=00000010", lat, PP, 8 + FIX_LAT);
    end
    count_done(hi);
    lo = 0;
    for (int i = 0; i < 50; i++) begin
      if (BUSY) break;
      lo++;
      @(posedge CLK); #1;
    end
    vectors++;
    if (hi !== HOLD || lo !== 1) begin
      miscompares++;
      $display("FAIL b2b_gap: DONE cycles=%0d idle cycles=%0d, required %0d and 1", hi, lo, HOLD);
    end
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge CLK); #1;
      if (DONE) begin lat = e; break; end
    end
    vectors++;
    if (lat !== 8 + FIX_LAT || PP !== 32'h10) begin
      miscompares++;
      $display("FAIL b2b_second: lat=%0d PP=%h, required lat=%0d PP=00000010", lat, PP, 8 + FIX_LAT);
    end
    START = 1'b0;
    wait_idle(idle);
    vectors++;
    if (!idle) begin miscompares++; $display("FAIL idle_timeout_b2b: BUSY=%b, required 0", BUSY); end
    $display("test_back_to_back: hold=%0d gap=%0d lat=%0d PP=%h", hi, lo, lat, PP);
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed;
    int lat;
    bit idle;
    run_op(16'hFFFD, 16'h0005, 0, lat);
    vectors++;
    if (lat !== 10 || PP !== 32'hFFFF_FFF1) begin
      miscompares++;
      $display("FAIL signed_m3x5: lat=%0d PP=%h, required lat=10 PP=fffffff1", lat, PP);
    end
    wait_idle(idle);
    run_op(16'h8000, 16'h8000, 0, lat);
    vectors++;
    if (lat !== 35 || PP !== 32'h4000_0000) begin
      miscompares++;
      $display("FAIL signed_min_sq: lat=%0d PP=%h, required lat=35 PP=40000000", lat, PP);
    end
    wait_idle(idle);
    vectors++;
    if (!idle) begin miscompares++; $display("FAIL idle_timeout_signed: BUSY=%b, required 0", BUSY); end
    $display("test_signed: lat=%0d PP=%h", lat, PP);
  endtask
`endif

  initial begin
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    test_reset();
    test_zero_operands();
    test_busy_ignore();
    test_max_operands();
    test_back_to_back();
`ifdef MULT_SIGNED_EN
    test_signed();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
